// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package mem_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_t;

  // Which requester owns the transaction in flight
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // Legal parameter ranges, checked at elaboration
  localparam int LAT_MIN    = 1;
  localparam int LAT_MAX    = 4;
  localparam int STREAK_MIN = 1;
  localparam int STREAK_MAX = 15;

endpackage

// File: rtl/arb_prio.sv
// Fetch/data pick logic with a data-streak counter that guarantees fetch progress.
// Latency: picks are combinational from the requests; streak updates on the grant edge.
// Backpressure: none; the loser simply keeps its request up until a later grant.
//
// Ports: clk, rst_n       clock, async active-low reset
//        i_req, d_req     current fetch / data requests
//        grant            high in the cycle a pick is committed (FSM idle with a request)
//        pick_d, pick_i   one-hot winner (both low when nobody requests)
module arb_prio
  import mem_arb_pkg::*;
#(
  parameter int MAX_STREAK = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req,
  input  logic d_req,
  input  logic grant,
  output logic pick_d,
  output logic pick_i
);

  if (MAX_STREAK < STREAK_MIN || MAX_STREAK > STREAK_MAX) begin : g_bad_streak
    $error("arb_prio: MAX_STREAK out of range");
  end

  localparam logic [3:0] STREAK_LIM = 4'(MAX_STREAK);

  logic [3:0] streak;
  logic       at_limit;

  assign at_limit = (streak == STREAK_LIM);

  // Data wins a tie unless fetch has already been passed over MAX_STREAK times
  assign pick_i = i_req & (~d_req | at_limit);
  assign pick_d = d_req & ~pick_i;

  // Only data grants that actually made fetch wait count toward the streak
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= 4'd0;
    end else if (grant) begin
      if (pick_i) begin
        streak <= 4'd0;
      end else if (pick_d && i_req && !at_limit) begin
        streak <= streak + 4'd1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory between fetch (read-only) and data (read/write).
// Latency: request sampled in idle cycle N -> m_en at N+1 -> ack pulse at N+1+LAT -> idle at N+2+LAT.
// Backpressure: requesters hold req until their ack; requests are only sampled while idle.
//
// Ports: clk, rst_n                    clock, async active-low reset
//        i_req/i_addr -> i_ack/i_rdata fetch port (rdata valid only with i_ack)
//        d_req/d_we/d_addr/d_wdata     data port request
//        d_ack/d_rdata                 data completion (rdata valid only with d_ack on reads)
//        m_en/m_we/m_addr/m_wdata      registered memory strobe and command
//        m_rdata                       memory read data, valid LAT cycles after m_en
//        busy                          high whenever a transaction is in flight
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 7,
  parameter int DW         = 32,
  parameter int LAT        = 2,
  parameter int MAX_STREAK = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy
);

  if (LAT < LAT_MIN || LAT > LAT_MAX) begin : g_bad_lat
    $error("mem_arbiter: LAT out of range");
  end

  // WAIT lasts LAT-1 cycles; the counter is loaded with LAT-2 and exits at zero
  localparam logic [2:0] WAIT_LOAD = 3'((LAT > 1) ? (LAT - 2) : 0);

  arb_state_t state;
  owner_t     owner;
  logic [2:0] wait_cnt;
  logic       grant;
  logic       pick_d;
  logic       pick_i;

  assign grant = (state == ST_IDLE) && (i_req || d_req);

  arb_prio #(
    .MAX_STREAK(MAX_STREAK)
  ) u_prio (
    .clk   (clk),
    .rst_n (rst_n),
    .i_req (i_req),
    .d_req (d_req),
    .grant (grant),
    .pick_d(pick_d),
    .pick_i(pick_i)
  );

  // Read data is a straight pass-through, exposed only to the port being acked
  assign i_rdata = i_ack ? m_rdata : '0;
  assign d_rdata = d_ack ? m_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      owner    <= OWN_I;
      wait_cnt <= 3'd0;
      m_en     <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      i_ack    <= 1'b0;
      d_ack    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      // Strobes are single-cycle pulses unless re-asserted below
      m_en  <= 1'b0;
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant) begin
            owner  <= pick_d ? OWN_D : OWN_I;
            m_en   <= 1'b1;
            m_we   <= pick_d & d_we;
            m_addr <= pick_d ? d_addr : i_addr;
            // Fetch grants leave the last write data in place
            if (pick_d) begin
              m_wdata <= d_wdata;
            end
            busy  <= 1'b1;
            state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (LAT > 1) begin
            wait_cnt <= WAIT_LOAD;
            state    <= ST_WAIT;
          end else begin
            i_ack <= (owner == OWN_I);
            d_ack <= (owner == OWN_D);
            state <= ST_RESP;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 3'd0) begin
            i_ack <= (owner == OWN_I);
            d_ack <= (owner == OWN_D);
            state <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        ST_RESP: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (LAT=2, LAT=1, LAT=4), each with its own memory model.
// Latency: expected ack cycles are computed when stimulus is driven and checked by a scoreboard.
// Backpressure: bench requesters hold req until ack and drop it on the edge ending the ack cycle.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic        i_req   [3];
  logic [6:0]  i_addr  [3];
  logic        i_ack   [3];
  logic [31:0] i_rdata [3];
  logic        d_req   [3];
  logic        d_we    [3];
  logic [6:0]  d_addr  [3];
  logic [31:0] d_wdata [3];
  logic        d_ack   [3];
  logic [31:0] d_rdata [3];
  logic        m_en    [3];
  logic        m_we    [3];
  logic [6:0]  m_addr  [3];
  logic [31:0] m_wdata [3];
  logic [31:0] m_rdata [3];
  logic        busy    [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_arbiter #(
      .AW(7), .DW(32), .LAT((g == 0) ? 2 : ((g == 1) ? 1 : 4)), .MAX_STREAK(3)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req[g]), .i_addr(i_addr[g]), .i_ack(i_ack[g]), .i_rdata(i_rdata[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_ack(d_ack[g]), .d_rdata(d_rdata[g]),
      .m_en(m_en[g]), .m_we(m_we[g]), .m_addr(m_addr[g]), .m_wdata(m_wdata[g]),
      .m_rdata(m_rdata[g]), .busy(busy[g])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
  endfunction

  // Unwritten memory words hold 0x20020000 + 2*addr
  function automatic logic [31:0] init_word(input logic [6:0] a);
    return 32'h2002_0000 + {24'd0, a, 1'b0};
  endfunction

  // Memory model: writes land on the strobe edge; read data appears exactly LAT cycles after m_en
  logic [31:0] memw [3][128];
  bit          wrv  [3][128];
  bit          rd_v [3][4];
  logic [6:0]  rd_a [3][4];

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (m_en[k] && m_we[k]) begin
        memw[k][m_addr[k]] <= m_wdata[k];
        wrv[k][m_addr[k]]  <= 1'b1;
      end
      rd_v[k][0] <= m_en[k] && !m_we[k];
      rd_a[k][0] <= m_addr[k];
      for (int s = 1; s < 4; s++) begin
        rd_v[k][s] <= rd_v[k][s-1];
        rd_a[k][s] <= rd_a[k][s-1];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      m_rdata[k] = 32'hBAD0_BAD0;
      if (rd_v[k][lat_of(k)-1]) begin
        m_rdata[k] = wrv[k][rd_a[k][lat_of(k)-1]] ? memw[k][rd_a[k][lat_of(k)-1]]
                                                   : init_word(rd_a[k][lat_of(k)-1]);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard of expected acknowledgements
  typedef struct {
    int          k;
    logic        own_d;
    logic        chk_data;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        if (i_ack[k] || d_ack[k]) begin
          exp_t e;
          chk("ack_exclusive", {31'd0, i_ack[k] & d_ack[k]}, 32'd0);
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: inst %0d acked at cycle %0d, expected no ack", k, cyc);
          end else begin
            e = sb.pop_front();
            chk("ack_inst", k, e.k);
            chk("ack_owner_d", {31'd0, d_ack[k]}, {31'd0, e.own_d});
            chk("ack_cycle", cyc, e.cyc);
            if (e.chk_data) chk("ack_rdata", e.own_d ? d_rdata[k] : i_rdata[k], e.rdata);
          end
        end
      end
    end
  end

  task automatic wait_ack(input int k, input int lim);
    bit seen = 1'b0;
    for (int g = 0; g < lim && !seen; g++) begin
      @(negedge clk);
      seen = i_ack[k] || d_ack[k];
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: inst %0d gave no ack within %0d cycles, expected one", k, lim);
      sb.delete();
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    int          k;
    logic        is_d;
    logic        we;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        chg;
  } vec_t;

  task automatic apply_vec(input vec_t v);
    int n;
    @(posedge clk); #1;
    n = cyc;
    if (v.is_d) begin
      d_req[v.k] = 1'b1; d_we[v.k] = v.we; d_addr[v.k] = v.addr; d_wdata[v.k] = v.wdata;
    end else begin
      i_req[v.k] = 1'b1; i_addr[v.k] = v.addr;
    end
    sb.push_back('{v.k, v.is_d, !v.we, v.rdata, n + 1 + lat_of(v.k)});
    @(posedge clk); #1;
    chk("issue_m_en", {31'd0, m_en[v.k]}, 32'd1);
    chk("issue_m_we", {31'd0, m_we[v.k]}, {31'd0, v.we});
    chk("issue_m_addr", {25'd0, m_addr[v.k]}, {25'd0, v.addr});
    if (v.we) chk("issue_m_wdata", m_wdata[v.k], v.wdata);
    chk("issue_busy", {31'd0, busy[v.k]}, 32'd1);
    // Request fields changed after the grant must not reach the memory
    if (v.chg) begin
      i_addr[v.k] = ~v.addr; d_addr[v.k] = ~v.addr; d_wdata[v.k] = ~v.wdata;
    end
    wait_ack(v.k, 20);
    @(posedge clk); #1;
    i_req[v.k] = 1'b0; d_req[v.k] = 1'b0; d_we[v.k] = 1'b0;
    chk("done_busy", {31'd0, busy[v.k]}, 32'd0);
    chk("done_m_en", {31'd0, m_en[v.k]}, 32'd0);
  endtask

  // Both ports on instance 0; data requests continuously, fetch joins after 'pre' data grants
  task automatic streak_run(input int pre, input int total, input logic [15:0] order);
    int n;
    int acks = 0;
    int guard = 0;
    pulse_reset();
    @(posedge clk); #1;
    n = cyc;
    for (int j = 0; j < total; j++)
      sb.push_back('{0, order[j], 1'b1, order[j] ? init_word(7'h30) : init_word(7'h20), n + 3 + 4*j});
    d_addr[0] = 7'h30; d_we[0] = 1'b0; i_addr[0] = 7'h20;
    d_req[0] = 1'b1; i_req[0] = (pre == 0);
    while (acks < total && guard < 100) begin
      @(negedge clk);
      guard++;
      if (i_ack[0] || d_ack[0]) begin
        acks++;
        if (acks == pre) begin
          @(posedge clk); #1;
          i_req[0] = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    i_req[0] = 1'b0; d_req[0] = 1'b0;
    if (acks < total) begin
      checks++;
      errors++;
      $display("FAIL streak_timeout: got %0d acks, expected %0d", acks, total);
      sb.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[11];
    int   n;
    //          k  d     we    addr   wdata          rdata                chg
    vecs[0]  = '{0, 1'b0, 1'b0, 7'h05, 32'h0,         32'h2002_000A,       1'b0};
    vecs[1]  = '{0, 1'b1, 1'b1, 7'h10, 32'hDEADBEEF,  32'h0,               1'b0};
    vecs[2]  = '{0, 1'b1, 1'b0, 7'h10, 32'h0,         32'hDEADBEEF,        1'b0};
    vecs[3]  = '{0, 1'b1, 1'b1, 7'h7F, 32'h1234_5678, 32'h0,               1'b0};
    vecs[4]  = '{0, 1'b0, 1'b0, 7'h7F, 32'h0,         32'h1234_5678,       1'b0};
    vecs[5]  = '{0, 1'b0, 1'b0, 7'h00, 32'h0,         32'h2002_0000,       1'b0};
    vecs[6]  = '{1, 1'b0, 1'b0, 7'h11, 32'h0,         32'h2002_0022,       1'b1};
    vecs[7]  = '{1, 1'b1, 1'b1, 7'h22, 32'hCAFE_F00D, 32'h0,               1'b1};
    vecs[8]  = '{1, 1'b1, 1'b0, 7'h22, 32'h0,         32'hCAFE_F00D,       1'b0};
    vecs[9]  = '{2, 1'b0, 1'b0, 7'h33, 32'h0,         32'h2002_0066,       1'b1};
    vecs[10] = '{2, 1'b1, 1'b0, 7'h44, 32'h0,         32'h2002_0088,       1'b0};

    for (int k = 0; k < 3; k++) begin
      i_req[k] = 1'b0; i_addr[k] = '0; d_req[k] = 1'b0; d_we[k] = 1'b0;
      d_addr[k] = '0; d_wdata[k] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_m_en", {31'd0, m_en[k]}, 32'd0);
      chk("rst_m_we", {31'd0, m_we[k]}, 32'd0);
      chk("rst_m_addr", {25'd0, m_addr[k]}, 32'd0);
      chk("rst_m_wdata", m_wdata[k], 32'd0);
      chk("rst_acks", {30'd0, i_ack[k], d_ack[k]}, 32'd0);
      chk("rst_busy", {31'd0, busy[k]}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) apply_vec(vecs[i]);

    // Reset asserted during WAIT of a fetch: outputs clear at once, no ack, request re-granted
    @(posedge clk); #1;
    i_addr[0] = 7'h05; i_req[0] = 1'b1;
    @(posedge clk); #1;
    chk("midrst_m_en", {31'd0, m_en[0]}, 32'd1);
    @(posedge clk); #1;
    chk("midrst_busy_before", {31'd0, busy[0]}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_m_addr", {25'd0, m_addr[0]}, 32'd0);
    chk("midrst_busy", {31'd0, busy[0]}, 32'd0);
    chk("midrst_m_en_we", {30'd0, m_en[0], m_we[0]}, 32'd0);
    @(posedge clk); #1;
    chk("midrst_no_ack", {30'd0, i_ack[0], d_ack[0]}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    n = cyc;
    sb.push_back('{0, 1'b0, 1'b1, 32'h2002_000A, n + 3});
    wait_ack(0, 20);
    @(posedge clk); #1;
    i_req[0] = 1'b0;

    // Continuous contention: d,d,d,i,d,d,d,i
    streak_run(0, 8, 16'h0077);
    // Five uncontested data grants leave the streak at zero: d x5, then d,d,d,i
    streak_run(5, 9, 16'h00FF);

    repeat (10) @(posedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
